// File: rtl/pwm_cfg_sequencer.sv
// pwm_cfg_sequencer: bus master that programs NCH PWM channels.
// Each channel gets three writes in a fixed order: duty, period, enable.
// Every write is SETUP -> WRITE (wait for ack or timeout) -> RELEASE.
// Enable is written last, so a channel is never switched on with stale timing.
module pwm_cfg_sequencer #(
  parameter int NCH       = 2,
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int BASE      = 0,
  parameter int CH_STRIDE = 32,
  parameter int ENA_OFF   = 0,
  parameter int PER_OFF   = 4,
  parameter int DUTY_OFF  = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic [NCH*DW-1:0] period_in,
  input  logic [NCH*DW-1:0] duty_in,
  input  logic [NCH-1:0]    ch_en,
  input  logic              ack,
  output logic [AW-1:0]     adr,
  output logic              cs,
  output logic              wr,
  output logic              rd,
  output logic [DW-1:0]     d_in,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_RELEASE} state_t;
  typedef enum logic [1:0] {R_DUTY, R_PER, R_ENA} reg_t;

  state_t            state_q, state_d;
  reg_t              reg_q, reg_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [DW-1:0]     d_in_q, d_in_d;
  logic [NCH*DW-1:0] per_q, duty_q;
  logic [NCH-1:0]    en_q;

  logic              snap;   // capture inputs this edge
  logic              load;   // load adr/d_in for the write entered next
  logic [NCH*DW-1:0] per_src, duty_src;
  logic [NCH-1:0]    en_src;
  logic [DW-1:0]     per_sel, duty_sel;
  logic [AW-1:0]     off_sel;

  // Next-state logic: sequencing, timeout, and bus address/data selection
  always_comb begin
    state_d  = state_q;
    reg_d    = reg_q;
    ch_d     = ch_q;
    timer_d  = timer_q;
    err_d    = err_q;
    done_d   = 1'b0;
    adr_d    = adr_q;
    d_in_d   = d_in_q;
    snap     = 1'b0;
    load     = 1'b0;
    per_sel  = '0;
    duty_sel = '0;
    off_sel  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap    = 1'b1;
          load    = 1'b1;
          ch_d    = '0;
          reg_d   = R_DUTY;
          err_d   = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        timer_d = '0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (ack) begin
          timer_d = '0;
          state_d = S_RELEASE;
        end else if (timer_q >= TW'(TIMEOUT - 1)) begin
          timer_d = '0;
          err_d   = 1'b1;
          state_d = S_RELEASE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RELEASE: begin
        timer_d = '0;
        case (reg_q)
          R_DUTY: begin
            reg_d   = R_PER;
            load    = 1'b1;
            state_d = S_SETUP;
          end
          R_PER: begin
            reg_d   = R_ENA;
            load    = 1'b1;
            state_d = S_SETUP;
          end
          default: begin
            if (ch_q != CW'(NCH - 1)) begin
              ch_d    = ch_q + CW'(1);
              reg_d   = R_DUTY;
              load    = 1'b1;
              state_d = S_SETUP;
            end else if (continuous) begin
              snap    = 1'b1;
              load    = 1'b1;
              ch_d    = '0;
              reg_d   = R_DUTY;
              state_d = S_SETUP;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    // A fresh snapshot is visible to the first write of the pass it starts
    per_src  = snap ? period_in : per_q;
    duty_src = snap ? duty_in   : duty_q;
    en_src   = snap ? ch_en     : en_q;

    if (load) begin
      per_sel  = per_src[ch_d*DW +: DW];
      duty_sel = duty_src[ch_d*DW +: DW];
      case (reg_d)
        R_DUTY: begin
          off_sel = AW'(DUTY_OFF);
          d_in_d  = (duty_sel > per_sel) ? per_sel : duty_sel;
        end
        R_PER: begin
          off_sel = AW'(PER_OFF);
          d_in_d  = per_sel;
        end
        default: begin
          off_sel = AW'(ENA_OFF);
          d_in_d  = DW'(en_src[ch_d]);
        end
      endcase
      adr_d = AW'(BASE) + AW'(CH_STRIDE) * AW'(ch_d) + off_sel;
    end
  end

  // State and bus registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      reg_q   <= R_DUTY;
      ch_q    <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      adr_q   <= '0;
      d_in_q  <= '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      ch_q    <= ch_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      done_q  <= done_d;
      adr_q   <= adr_d;
      d_in_q  <= d_in_d;
    end
  end

  // Input snapshot taken at the start of every pass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_q  <= '0;
      duty_q <= '0;
      en_q   <= '0;
    end else if (snap) begin
      per_q  <= period_in;
      duty_q <= duty_in;
      en_q   <= ch_en;
    end
  end

  // Strobes decode straight from state so reset clears them without a clock
  assign cs   = (state_q == S_SETUP) || (state_q == S_WRITE);
  assign wr   = (state_q == S_WRITE);
  assign rd   = 1'b0;
  assign busy = (state_q != S_IDLE);
  assign adr  = adr_q;
  assign d_in = d_in_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
